delay_line_seq: RTL and testbench



---
 rtl/delay_line_seq.sv | 162 ++++++++++++++++
 tb/tb_delay_line_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/delay_line_seq.sv
// Sequencer for an enable-gated pixel delay line: drives the clock enable, carries
// valid/SOF/EOL tags alongside the pipeline, and flushes DELAY bubbles at end of line.
module delay_line_seq #(
  parameter int DELAY  = 4,
  parameter int LCNT_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_sof,
  input  logic              i_eol,
  input  logic              i_eof,
  output logic              o_ready,
  output logic              o_ce,
  output logic              o_valid,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_busy,
  output logic              o_err,
  output logic [LCNT_W-1:0] o_lines
);

  localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                eof_q, eof_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LCNT_W-1:0]   lines_q, lines_d;
  logic [DELAY-1:0]    vtag_q, vtag_d;
  logic [DELAY-1:0]    stag_q, stag_d;
  logic [DELAY-1:0]    etag_q, etag_d;
  logic                vld_q, vld_d;
  logic                sof_q, sof_d;
  logic                eol_q, eol_d;
  logic                err_q, err_d;
  logic                ce, ready, busy;
  logic                tv_in, ts_in, te_in;

  function automatic logic [LCNT_W-1:0] sat_inc(input logic [LCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    eof_d   = eof_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    ce      = 1'b0;
    ready   = 1'b1;
    busy    = 1'b0;
    err_d   = 1'b0;
    tv_in   = 1'b0;
    ts_in   = 1'b0;
    te_in   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          // Only a start-of-frame beat may open a frame; anything else is dropped.
          if (i_sof) begin
            ce      = 1'b1;
            tv_in   = 1'b1;
            ts_in   = 1'b1;
            te_in   = i_eol;
            lines_d = '0;
            if (i_eol) begin
              state_d = DRAIN;
              eof_d   = i_eof;
            end else begin
              state_d = RUN;
            end
          end else begin
            err_d = 1'b1;
          end
          if (i_eof && !i_eol) err_d = 1'b1;
        end
      end
      RUN: begin
        ce = i_valid;
        if (i_valid) begin
          tv_in = 1'b1;
          ts_in = i_sof;
          te_in = i_eol;
          if (i_sof || (i_eof && !i_eol)) err_d = 1'b1;
          if (i_eol) begin
            state_d = DRAIN;
            eof_d   = i_eof;
          end
        end
      end
      DRAIN: begin
        ready = 1'b0;
        ce    = 1'b1;
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          lines_d = sat_inc(lines_q);
          state_d = eof_q ? IDLE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    vtag_d = vtag_q;
    stag_d = stag_q;
    etag_d = etag_q;
    if (ce) begin
      vtag_d[0] = tv_in;
      stag_d[0] = ts_in;
      etag_d[0] = te_in;
      for (int i = 1; i < DELAY; i++) begin
        vtag_d[i] = vtag_q[i-1];
        stag_d[i] = stag_q[i-1];
        etag_d[i] = etag_q[i-1];
      end
    end
    vld_d = ce && vtag_d[DELAY-1];
    sof_d = vld_d && stag_d[DELAY-1];
    eol_d = vld_d && etag_d[DELAY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      eof_q   <= 1'b0;
      cnt_q   <= '0;
      lines_q <= '0;
      vtag_q  <= '0;
      stag_q  <= '0;
      etag_q  <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      eof_q   <= eof_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      vtag_q  <= vtag_d;
      stag_q  <= stag_d;
      etag_q  <= etag_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      err_q   <= err_d;
    end
  end

  assign o_ready = ready;
  assign o_ce    = ce;
  assign o_busy  = busy;
  assign o_valid = vld_q;
  assign o_sof   = sof_q;
  assign o_eol   = eol_q;
  assign o_err   = err_q;
  assign o_lines = lines_q;

endmodule

// File: tb/tb_delay_line_seq.sv
// Directed bench for delay_line_seq: three depths (1, 3, 4) share one input stream.
module tb_delay_line_seq;

  logic clk, rst_n;
  logic i_valid, i_sof, i_eol, i_eof;

  logic r1, c1, v1, s1, e1, b1, x1;
  logic r3, c3, v3, s3, e3, b3, x3;
  logic r4, c4, v4, s4, e4, b4, x4;
  logic [10:0] l1, l3, l4;

  int nvec = 0;
  int nerr = 0;

  delay_line_seq #(.DELAY(1), .LCNT_W(11)) u1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_eol(i_eol), .i_eof(i_eof),
    .o_ready(r1), .o_ce(c1), .o_valid(v1), .o_sof(s1), .o_eol(e1), .o_busy(b1), .o_err(x1),
    .o_lines(l1));

  delay_line_seq #(.DELAY(3), .LCNT_W(11)) u3 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_eol(i_eol), .i_eof(i_eof),
    .o_ready(r3), .o_ce(c3), .o_valid(v3), .o_sof(s3), .o_eol(e3), .o_busy(b3), .o_err(x3),
    .o_lines(l3));

  delay_line_seq #(.DELAY(4), .LCNT_W(11)) u4 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_eol(i_eol), .i_eof(i_eof),
    .o_ready(r4), .o_ce(c4), .o_valid(v4), .o_sof(s4), .o_eol(e4), .o_busy(b4), .o_err(x4),
    .o_lines(l4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge; outputs are sampled 2 ns after the edge.
  task automatic step(input logic v, input logic s, input logic e, input logic f);
    @(posedge clk);
    #1;
    i_valid = v; i_sof = s; i_eol = e; i_eof = f;
    #1;
  endtask

  task automatic rst_seq();
    rst_n = 1'b0;
    i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0; i_eof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst vld", v3, 0);
    chk("rst busy", b3, 0);
    chk("rst lines", l3, 0);
    chk("rst err", x3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst ready", r3, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0; i_eof = 1'b0;

    // T1: DELAY=3, contiguous five-pixel single-line frame
    rst_seq();
    for (int c = 0; c < 9; c++) begin
      case (c)
        0:       step(1, 1, 0, 0);
        1, 2, 3: step(1, 0, 0, 0);
        4:       step(1, 0, 1, 1);
        default: step(0, 0, 0, 0);
      endcase
      chk($sformatf("t1 vld c%0d", c), v3, (c >= 3 && c <= 7));
      chk($sformatf("t1 sof c%0d", c), s3, (c == 3));
      chk($sformatf("t1 eol c%0d", c), e3, (c == 7));
      chk($sformatf("t1 rdy c%0d", c), r3, !(c >= 5 && c <= 7));
    end
    chk("t1 lines", l3, 1);
    chk("t1 idle busy", b3, 0);

    // T2: DELAY=3, same line with a gap after every pixel
    n = 0;
    for (int c = 0; c < 13; c++) begin
      logic v;
      v = (c % 2 == 0) && (c <= 8);
      step(v, c == 0, c == 8, c == 8);
      chk($sformatf("t2 ce c%0d", c), c3, (c <= 8) ? v : (c <= 11));
      chk($sformatf("t2 vld c%0d", c), v3, (c == 5 || c == 7 || c == 9 || c == 10 || c == 11));
      chk($sformatf("t2 eol c%0d", c), e3, (c == 11));
      if (v3) n++;
    end
    chk("t2 strobes", n, 5);
    chk("t2 lines", l3, 1);

    // T3: DELAY=3, two-line frame
    rst_seq();
    n = 0;
    for (int c = 0; c < 11; c++) begin
      case (c)
        0:       step(1, 1, 0, 0);
        1:       step(1, 0, 1, 0);
        5:       step(1, 0, 0, 0);
        6:       step(1, 0, 1, 1);
        default: step(0, 0, 0, 0);
      endcase
      chk($sformatf("t3 busy c%0d", c), b3, ((c >= 2 && c <= 4) || (c >= 7 && c <= 9)));
      chk($sformatf("t3 vld c%0d", c), v3, (c == 3 || c == 4 || c == 8 || c == 9));
      if (s3) n++;
    end
    chk("t3 sof count", n, 1);
    chk("t3 lines", l3, 2);
    chk("t3 ready", r3, 1);

    // T4: DELAY=1, one-pixel frame
    rst_seq();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) step(1, 1, 1, 1);
      else        step(0, 0, 0, 0);
      chk($sformatf("t4 vld c%0d", c), v1, (c == 1));
      chk($sformatf("t4 sof c%0d", c), s1, (c == 1));
      chk($sformatf("t4 eol c%0d", c), e1, (c == 1));
      chk($sformatf("t4 busy c%0d", c), b1, (c == 1));
    end
    chk("t4 lines", l1, 1);
    chk("t4 ready", r1, 1);

    // T5: DELAY=3, protocol violations
    rst_seq();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0:       step(1, 0, 0, 0);
        2, 3:    step(1, 1, 0, 0);
        4:       step(1, 0, 0, 1);
        5:       step(1, 0, 1, 1);
        default: step(0, 0, 0, 0);
      endcase
      if (c == 0) chk("t5 drop ce", c3, 0);
      chk($sformatf("t5 err c%0d", c), x3, (c == 1 || c == 4 || c == 5));
      chk($sformatf("t5 vld c%0d", c), v3, (c >= 5 && c <= 8));
      if (x3) n++;
    end
    chk("t5 err count", n, 3);

    // T6: DELAY=4, asynchronous reset during the second drain cycle
    rst_seq();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       step(1, 1, 0, 0);
        1:       step(1, 0, 1, 0);
        default: step(0, 0, 0, 0);
      endcase
    end
    chk("t6 busy pre", b4, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 async busy", b4, 0);
    chk("t6 async vld", v4, 0);
    chk("t6 async lines", l4, 0);
    chk("t6 async err", x4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 0, 0);
      chk($sformatf("t6 post vld c%0d", c), v4, 0);
      chk($sformatf("t6 post ce c%0d", c), c4, 0);
      chk($sformatf("t6 post rdy c%0d", c), r4, 1);
    end
    for (int c = 0; c < 6; c++) begin
      if (c == 0) step(1, 1, 1, 1);
      else        step(0, 0, 0, 0);
      chk($sformatf("t6 new vld c%0d", c), v4, (c == 4));
    end
    chk("t6 lines", l4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
